// File: rtl/periph_access_ctrl.sv
// Single-master APB-style access sequencer: IDLE -> SETUP -> ACCESS -> RESP per request.
// Define PERIPH_TIMEOUT_EN to bound the ACCESS wait at TIMEOUT_CYCLES with a fault response.
module periph_access_ctrl #(
    parameter int PA_BITS        = 34,
    parameter int XLEN           = 64,
    parameter int NPERIPH        = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic [PA_BITS-1:0]      ReqAdr,
    input  logic                    ReqWrite,
    input  logic [XLEN-1:0]         ReqWData,
    input  logic [1:0]              ReqSize,
    input  logic [NPERIPH-1:0]      SelVec,
    output logic [NPERIPH-1:0]      PSel,
    output logic                    PEnable,
    output logic [PA_BITS-1:0]      PAdr,
    output logic                    PWrite,
    output logic [XLEN-1:0]         PWData,
    output logic [1:0]              PSize,
    input  logic [NPERIPH-1:0]      PReadyVec,
    input  logic [NPERIPH*XLEN-1:0] PRDataVec,
    output logic                    RspValid,
    input  logic                    RspReady,
    output logic [XLEN-1:0]         RspData,
    output logic                    RspFault
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state;
    logic [NPERIPH-1:0]  sel_p0;
    logic                ready_sel;
    logic [XLEN-1:0]     rdata_sel;

`ifdef PERIPH_TIMEOUT_EN
    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] tmo_cnt;
`endif

    function automatic logic is_onehot(input logic [NPERIPH-1:0] v);
        return (v != '0) && ((v & (v - NPERIPH'(1))) == '0);
    endfunction

    assign ReqReady = (state == IDLE);

    // Captured select is one-hot here, so an AND-OR mux picks the single slice.
    always_comb begin
        ready_sel = |(PReadyVec & sel_p0);
        rdata_sel = '0;
        for (int i = 0; i < NPERIPH; i++) begin
            if (sel_p0[i]) rdata_sel = rdata_sel | PRDataVec[i*XLEN +: XLEN];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sel_p0   <= '0;
            PSel     <= '0;
            PEnable  <= 1'b0;
            PAdr     <= '0;
            PWrite   <= 1'b0;
            PWData   <= '0;
            PSize    <= '0;
            RspValid <= 1'b0;
            RspFault <= 1'b0;
            RspData  <= '0;
`ifdef PERIPH_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        PAdr   <= ReqAdr;
                        PWrite <= ReqWrite;
                        PWData <= ReqWData;
                        PSize  <= ReqSize;
                        sel_p0 <= SelVec;
                        if (is_onehot(SelVec)) begin
                            PSel  <= SelVec;
                            state <= SETUP;
                        end else begin
                            // Decode fault: respond without touching the bus.
                            RspValid <= 1'b1;
                            RspFault <= 1'b1;
                            RspData  <= '0;
                            state    <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PEnable <= 1'b1;
`ifdef PERIPH_TIMEOUT_EN
                    tmo_cnt <= 16'd1;
`endif
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (ready_sel) begin
                        PSel     <= '0;
                        PEnable  <= 1'b0;
                        RspValid <= 1'b1;
                        RspFault <= 1'b0;
                        RspData  <= PWrite ? '0 : rdata_sel;
                        state    <= RESP;
                    end
`ifdef PERIPH_TIMEOUT_EN
                    else if (tmo_cnt >= TMO_LIM) begin
                        PSel     <= '0;
                        PEnable  <= 1'b0;
                        RspValid <= 1'b1;
                        RspFault <= 1'b1;
                        RspData  <= '0;
                        state    <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        RspFault <= 1'b0;
                        RspData  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_access_ctrl.sv
// Directed plus randomized bench for periph_access_ctrl against a cycle-count reference model.
module tb_periph_access_ctrl;
    localparam int PA  = 34;
    localparam int XL  = 64;
    localparam int NP  = 8;
    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ReqValid, ReqReady, ReqWrite;
    logic [PA-1:0]     ReqAdr;
    logic [XL-1:0]     ReqWData;
    logic [1:0]        ReqSize;
    logic [NP-1:0]     SelVec, PSel, PReadyVec;
    logic              PEnable, PWrite;
    logic [PA-1:0]     PAdr;
    logic [XL-1:0]     PWData;
    logic [1:0]        PSize;
    logic [NP*XL-1:0]  PRDataVec;
    logic              RspValid, RspReady, RspFault;
    logic [XL-1:0]     RspData;

    int tests = 0;
    int fails = 0;

    periph_access_ctrl #(.PA_BITS(PA), .XLEN(XL), .NPERIPH(NP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAdr(ReqAdr), .ReqWrite(ReqWrite),
        .ReqWData(ReqWData), .ReqSize(ReqSize), .SelVec(SelVec),
        .PSel(PSel), .PEnable(PEnable), .PAdr(PAdr), .PWrite(PWrite), .PWData(PWData),
        .PSize(PSize), .PReadyVec(PReadyVec), .PRDataVec(PRDataVec),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspFault(RspFault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP*XL-1:0] rand_pdata();
        logic [NP*XL-1:0] d;
        for (int i = 0; i < NP*2; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // wt = wait cycles before the selected ready rises; wt >= 99 means never.
    task automatic txn(input logic [NP-1:0] sel, input logic wr, input int wt,
                       input int rdly, input logic [NP*XL-1:0] pdata);
        logic [PA-1:0] adr;
        logic [XL-1:0] wd, exp_data;
        logic [1:0]    sz;
        logic          exp_fault;
        int            resp_cyc, idx;
        adr = PA'({$urandom(), $urandom()});
        wd  = {$urandom(), $urandom()};
        sz  = 2'($urandom());
        idx = 0;
        for (int i = 0; i < NP; i++) if (sel[i]) idx = i;
        exp_fault = ($countones(sel) != 1);
        if (exp_fault) resp_cyc = 1;
        else resp_cyc = 3 + wt;
`ifdef PERIPH_TIMEOUT_EN
        if (!exp_fault && wt >= TMO) begin
            exp_fault = 1'b1;
            resp_cyc  = 2 + TMO;
        end
`endif
        exp_data = (exp_fault || wr) ? '0 : pdata[idx*XL +: XL];

        chk("reqready_idle", 128'(ReqReady), 128'(1));
        ReqValid = 1'b1; ReqAdr = adr; ReqWrite = wr; ReqWData = wd; ReqSize = sz;
        SelVec = sel; PRDataVec = pdata;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        SelVec   = NP'($urandom());
        ReqAdr   = PA'({$urandom(), $urandom()});
        ReqWData = {$urandom(), $urandom()};
        ReqWrite = ~wr;
        for (int c = 1; c < resp_cyc; c++) begin
            chk("psel", 128'(PSel), 128'(sel));
            chk("penable", 128'(PEnable), 128'(c >= 2));
            chk("rspvalid_busy", 128'(RspValid), 128'(0));
            chk("reqready_busy", 128'(ReqReady), 128'(0));
            chk("padr", 128'(PAdr), 128'(adr));
            chk("pwdata", 128'(PWData), 128'(wd));
            chk("pwrite", 128'(PWrite), 128'(wr));
            chk("psize", 128'(PSize), 128'(sz));
            PReadyVec = (NP'($urandom()) & ~sel) | ((c >= 2 + wt) ? sel : '0);
            @(posedge clk); #1;
        end
        PReadyVec = NP'($urandom()) & ~sel;
        for (int k = 0; k <= rdly; k++) begin
            chk("rspvalid", 128'(RspValid), 128'(1));
            chk("rspdata", 128'(RspData), 128'(exp_data));
            chk("rspfault", 128'(RspFault), 128'(exp_fault));
            chk("psel_resp", 128'(PSel), 128'(0));
            chk("penable_resp", 128'(PEnable), 128'(0));
            chk("reqready_resp", 128'(ReqReady), 128'(0));
            RspReady = (k == rdly);
            @(posedge clk); #1;
        end
        RspReady = 1'b0;
        PReadyVec = '0;
        chk("rspvalid_done", 128'(RspValid), 128'(0));
        chk("reqready_done", 128'(ReqReady), 128'(1));
    endtask

    initial begin
        logic [NP*XL-1:0] pd;
        logic [NP-1:0]    s;
        int               wt;
        reset = 1'b1; ReqValid = 1'b0; ReqAdr = '0; ReqWrite = 1'b0; ReqWData = '0;
        ReqSize = '0; SelVec = '0; PReadyVec = '0; PRDataVec = '0; RspReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", 128'(PSel), 128'(0));
        chk("rst_penable", 128'(PEnable), 128'(0));
        chk("rst_rspvalid", 128'(RspValid), 128'(0));
        chk("rst_rspdata", 128'(RspData), 128'(0));
        chk("rst_padr", 128'(PAdr), 128'(0));
        chk("rst_pwdata", 128'(PWData), 128'(0));
        reset = 1'b0;
        chk("rst_reqready", 128'(ReqReady), 128'(1));

        // Read from peripheral 2 with zero wait.
        pd = rand_pdata();
        pd[2*XL +: XL] = 64'hDEADBEEF;
        txn(8'b0000_0100, 1'b0, 0, 0, pd);
        // Decode faults.
        txn(8'b0000_0000, 1'b0, 0, 0, rand_pdata());
        txn(8'b0000_0011, 1'b1, 0, 1, rand_pdata());
        // Write to peripheral 5 with four wait cycles and a slow consumer.
        txn(8'b0010_0000, 1'b1, 4, 3, rand_pdata());
`ifdef PERIPH_TIMEOUT_EN
        txn(8'b0000_1000, 1'b0, 99, 0, rand_pdata());
        txn(8'b0000_1000, 1'b0, TMO - 1, 0, rand_pdata());
`endif

        // Reset in the middle of ACCESS.
        ReqValid = 1'b1; ReqAdr = 34'h1_2345_6789; ReqWrite = 1'b0; SelVec = 8'b0100_0000;
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_psel", 128'(PSel), 128'(0));
        chk("midrst_penable", 128'(PEnable), 128'(0));
        chk("midrst_rspvalid", 128'(RspValid), 128'(0));
        chk("midrst_padr", 128'(PAdr), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        PReadyVec = '1;
        chk("midrst_reqready", 128'(ReqReady), 128'(1));
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst_norsp", 128'(RspValid), 128'(0));
        end
        PReadyVec = '0;

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) s = NP'($urandom());
            else s = NP'(1) << $urandom_range(0, NP - 1);
`ifdef PERIPH_TIMEOUT_EN
            wt = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, TMO - 1);
`else
            wt = $urandom_range(0, 5);
`endif
            txn(s, 1'($urandom()), wt, $urandom_range(0, 2), rand_pdata());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
